// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder: slice width,
// controller state encoding and the nibble-index width helper.
package adder_pkg;

    localparam int SLICE_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index; a one-nibble adder still needs a 1-bit index.
    function automatic int idx_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operation/result handshake bundle for nibble_serial_adder.
// NIBBLE_SERIAL_ADDER_SUBTRACT_EN adds the sub request bit.
interface nibble_serial_adder_if
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
);
    localparam int W = SLICE_WIDTH * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;

    modport master (
        output in_valid,
        output a,
        output b,
        output carry_in,
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
        output sub,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  carry_out
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  carry_in,
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output carry_out
    );

endinterface

// File: rtl/adder_slice_4.sv
// 4-bit ripple-carry slice built from full adders.
// Latency: combinational. Backpressure: none.
// Shared by every nibble of the serial adder.
module adder_slice_4
    import adder_pkg::*;
(
    input  logic [SLICE_WIDTH-1:0] a,
    input  logic [SLICE_WIDTH-1:0] b,
    input  logic                   cin,
    output logic [SLICE_WIDTH-1:0] s,
    output logic                   cout
);
    logic [SLICE_WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_WIDTH; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE_WIDTH];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two W-bit operands one nibble per cycle through a single 4-bit slice.
// Latency: NIBBLES cycles from accept to out_valid; one operation in flight.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// NIBBLE_SERIAL_ADDER_SUBTRACT_EN enables a-b via the sub request bit.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    nibble_serial_adder_if.slave bus
);
    localparam int IW = idx_width(NIBBLES);

    state_t                              state;
    state_t                              state_nxt;
    logic [IW-1:0]                       idx;
    logic [NIBBLES-1:0][SLICE_WIDTH-1:0] a_reg;
    logic [NIBBLES-1:0][SLICE_WIDTH-1:0] b_reg;
    logic [NIBBLES-1:0][SLICE_WIDTH-1:0] sum_reg;
    logic                                carry_reg;
    logic                                cout_reg;

    logic                   accept;
    logic                   last_nibble;
    logic                   sub_eff;
    logic [SLICE_WIDTH-1:0] slice_s;
    logic                   slice_c;

`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
    assign sub_eff = bus.sub;
`else
    assign sub_eff = 1'b0;
`endif

    assign accept      = bus.in_valid && (state == IDLE);
    assign last_nibble = (idx == IW'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last_nibble)   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    adder_slice_4 u_slice (
        .a    (a_reg[idx]),
        .b    (b_reg[idx]),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_c)
    );

    // Subtraction is a + ~b + 1, so the inversion and forced carry happen at capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= bus.a;
                        b_reg     <= sub_eff ? ~bus.b : bus.b;
                        carry_reg <= sub_eff | bus.carry_in;
                        sum_reg   <= '0;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= slice_s;
                    carry_reg    <= slice_c;
                    if (last_nibble) begin
                        idx      <= '0;
                        cout_reg <= slice_c;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum       = sum_reg;
    assign bus.carry_out = cout_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder against an arithmetic model.
module tb_nibble_serial_adder;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;
    typedef logic [W:0] val_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    nibble_serial_adder_if #(.NIBBLES(NIB)) bus ();

    nibble_serial_adder #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    function automatic val_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic ci, input logic sb);
        if (sb) return {1'b0, av} + {1'b0, ~bv} + val_t'(1);
        return {1'b0, av} + {1'b0, bv} + val_t'(ci);
    endfunction

    task automatic check(input string tag, input val_t obs, input val_t exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_sub(input logic sb);
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
        bus.sub = sb;
`else
        if (sb) $display("sub requested without subtract support");
`endif
    endtask

    // Runs one operation; optionally stalls in DONE and, if chain is set,
    // offers the next operation during the output handshake.
    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic sb, input int stall, input logic chain,
                         input logic [W-1:0] nav, input logic [W-1:0] nbv, input logic nci);
        val_t exp;
        int   c;
        exp = model(av, bv, ci, sb);
        check({tag, " in_ready idle"}, val_t'(bus.in_ready), val_t'(1));
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        bus.carry_in = ci;
        set_sub(sb);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.carry_in = 1'($urandom);
        check({tag, " in_ready run"}, val_t'(bus.in_ready), val_t'(0));
        c = 0;
        while (bus.out_valid !== 1'b1 && c < 20) begin
            bus.in_valid = 1'($urandom);
            @(posedge clk); #1;
            c++;
        end
        bus.in_valid = 1'b0;
        check({tag, " latency"}, val_t'(c), val_t'(NIB));
        check({tag, " sum"}, val_t'(bus.sum), val_t'(exp[W-1:0]));
        check({tag, " carry_out"}, val_t'(bus.carry_out), val_t'(exp[W]));
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'($urandom);
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            @(posedge clk); #1;
            check({tag, " stall out_valid"}, val_t'(bus.out_valid), val_t'(1));
            check({tag, " stall in_ready"}, val_t'(bus.in_ready), val_t'(0));
            check({tag, " stall sum"}, val_t'(bus.sum), val_t'(exp[W-1:0]));
            check({tag, " stall carry_out"}, val_t'(bus.carry_out), val_t'(exp[W]));
        end
        bus.out_ready = 1'b1;
        if (chain) begin
            bus.in_valid = 1'b1;
            bus.a        = nav;
            bus.b        = nbv;
            bus.carry_in = nci;
            set_sub(1'b0);
        end else begin
            bus.in_valid = 1'b0;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " out_valid after take"}, val_t'(bus.out_valid), val_t'(0));
        check({tag, " in_ready after take"}, val_t'(bus.in_ready), val_t'(1));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b0;
        set_sub(1'b0);

        @(posedge clk); #1;
        check("reset in_ready", val_t'(bus.in_ready), val_t'(1));
        check("reset out_valid", val_t'(bus.out_valid), val_t'(0));
        check("reset sum", val_t'(bus.sum), val_t'(0));
        check("reset carry_out", val_t'(bus.carry_out), val_t'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        do_op("basic", 16'h1234, 16'h0001, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        do_op("cin only", 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        do_op("top carry", 16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0);

        // Stall in DONE, then present the next op during the handshake cycle.
        do_op("backpressure", 16'hABCD, 16'h1111, 1'b1, 1'b0, 3, 1'b1,
              16'h0F0F, 16'hF0F0, 1'b1);
        do_op("chained", 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 0, 1'b0, '0, '0, 1'b0);

        // Reset sampled at the end of the second RUN cycle.
        bus.in_valid = 1'b1;
        bus.a        = 16'hFFFF;
        bus.b        = 16'h0001;
        bus.carry_in = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrun reset out_valid", val_t'(bus.out_valid), val_t'(0));
        check("midrun reset in_ready", val_t'(bus.in_ready), val_t'(1));
        check("midrun reset sum", val_t'(bus.sum), val_t'(0));
        check("midrun reset carry_out", val_t'(bus.carry_out), val_t'(0));
        do_op("after reset", 16'h0003, 16'h0004, 1'b0, 1'b0, 0, 1'b0, '0, '0, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
        do_op("sub borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, '0, '0, 1'b0);
        do_op("sub no borrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0, '0, '0, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADDER_SUBTRACT_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op("random", ra, rb, rc, rs, int'($urandom_range(0, 3)), 1'b0, '0, '0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
